// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state encoding and the index-width helper.
package nibble_serial_add_ctrl_pkg;

    localparam int NW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest width able to index n nibbles (n >= 2).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle for the nibble-serial adder.
// master drives operands and consumes results; slave is the adder.
interface nibble_serial_add_ctrl_if #(
    parameter int NIB = 4
);
    import nibble_serial_add_ctrl_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [NW*NIB-1:0]   a;
    logic [NW*NIB-1:0]   b;
    logic                sub;
    logic                cin;
    logic                out_valid;
    logic                out_ready;
    logic [NW*NIB-1:0]   sum;
    logic                cout;

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );

endinterface

// File: rtl/nibble_serial_add_ctrl_rca.sv
// 4-bit ripple-carry adder shared by the nibble-serial datapath.
// Pure combinational full-adder chain.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i])
                      | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract unit: one 4-bit adder reused NIB times,
// LSB nibble first, with valid/ready on both request and result.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_add_ctrl_if.slave   bus,
    output logic                      busy
);

    localparam int W  = NW * NIB;
    localparam int IW = clog2(NIB);

    state_t          state;
    state_t          nstate;

    logic            armed;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx;
    logic            cy;
    logic            cout_q;

    logic [NW-1:0]   na;
    logic [NW-1:0]   nb;
    logic [NW-1:0]   ns;
    logic            nco;

    logic            accept;
    logic            consume;
    logic            last;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;
    assign last    = (idx == IW'(NIB - 1));

    assign na = a_q[NW*idx +: NW];
    assign nb = b_q[NW*idx +: NW];

    ripple_carry_adder u_rca (
        .a  (na),
        .b  (nb),
        .ci (cy),
        .s  (ns),
        .co (nco)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (accept)  nstate = RUN;
            RUN:  if (last)    nstate = DONE;
            DONE: if (consume) nstate = IDLE;
            default:           nstate = IDLE;
        endcase
    end

    // in_ready stays low while reset is held and until the first edge after it.
    always_comb begin
        bus.in_ready  = (state == IDLE) && armed;
        bus.out_valid = (state == DONE);
        busy          = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            cy     <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            unique case (1'b1)
                accept: begin
                    a_q    <= bus.a;
                    b_q    <= bus.sub ? ~bus.b : bus.b;
                    cy     <= bus.sub | bus.cin;
                    idx    <= '0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end
                busy: begin
                    sum_q[NW*idx +: NW] <= ns;
                    cy                  <= nco;
                    idx                 <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout_q <= nco;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and random checks for the nibble-serial adder (NIB=4).
// Expected results are hand-computed or taken from an integer model.
module tb_nibble_serial_add_ctrl;

    logic clk;
    logic rst_n;
    logic busy;

    int nchecks;
    int nerrors;
    int acc_cnt;
    int res_cnt;
    bit mon_en;

    nibble_serial_add_ctrl_if #(.NIB(4)) bus ();

    nibble_serial_add_ctrl #(.NIB(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en) begin
            if (bus.in_valid && bus.in_ready)   acc_cnt <= acc_cnt + 1;
            if (bus.out_valid && bus.out_ready) res_cnt <= res_cnt + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge; returns just after a negedge with the
    // result consumed and the block back in IDLE.
    task automatic run_op(input string       tag,
                          input logic [15:0] ta,
                          input logic [15:0] tb_v,
                          input logic        ts,
                          input logic        tc,
                          input int          hold,
                          input logic [15:0] esum,
                          input logic        ecout);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.sub       = ts;
        bus.cin       = tc;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.sub      = ~ts;
        bus.cin      = ~tc;
        check($sformatf("%s busy", tag), 32'(busy), 32'd1);
        k = 1;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("%s latency", tag), k, 32'd5);
        check($sformatf("%s sum", tag), 32'(bus.sum), 32'(esum));
        check($sformatf("%s cout", tag), 32'(bus.cout), 32'(ecout));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
            check($sformatf("%s hold rdy", tag), 32'(bus.in_ready), 32'd0);
            check($sformatf("%s hold ov", tag), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s hold sum", tag), 32'(bus.sum), 32'(esum));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("%s consumed", tag), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s rdy again", tag), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [16:0] r;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rc;
        bit          seen;

        nchecks       = 0;
        nerrors       = 0;
        acc_cnt       = 0;
        res_cnt       = 0;
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(bus.sum), 32'd0);
        check("rst cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("post rst rdy", 32'(bus.in_ready), 32'd1);

        run_op("add",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 16'h2233, 1'b0);
        run_op("wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 16'h0000, 1'b1);
        run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0);
        run_op("sub2", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1);
        run_op("bp",   16'h00FF, 16'h0001, 1'b0, 1'b0, 10, 16'h0100, 1'b0);
        run_op("aftbp", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 0, 16'h0000, 1'b1);
        run_op("msb",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 2, 16'h8000, 1'b0);

        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid busy", 32'(busy), 32'd0);
        check("mid ov", 32'(bus.out_valid), 32'd0);
        check("mid sum", 32'(bus.sum), 32'd0);
        check("mid rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid no ov", 32'(seen), 32'd0);
        run_op("aftrst", 16'h1111, 16'h2222, 1'b0, 1'b0, 0, 16'h3333, 1'b0);

        mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (rs) r = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
            else    r = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_op("rnd", ra, rb, rs, rc, int'($urandom_range(0, 3)),
                   r[15:0], r[16]);
        end
        @(negedge clk);
        check("accepts", acc_cnt, 32'd1000);
        check("results", res_cnt, 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIB, default 4, meaning the number of 4-bit nibbles per operand, legal range 2..8.
REQ-002 The block SHALL have port clk, input, width 1: the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, width 1: the operand request is valid.
REQ-005 The block SHALL have port in_ready, output, width 1: the block can accept an operand request.
REQ-006 The block SHALL have port a, input, width 4*NIB: operand A.
REQ-007 The block SHALL have port b, input, width 4*NIB: operand B.
REQ-008 The block SHALL have port sub, input, width 1: 0 selects A+B+cin; 1 selects A-B, computed as A+~B+1.
REQ-009 The block SHALL have port cin, input, width 1: carry-in for add mode; it is ignored when sub=1.
REQ-010 The block SHALL have port out_valid, output, width 1: the result is valid.
REQ-011 The block SHALL have port out_ready, input, width 1: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, width 4*NIB: the result.
REQ-013 The block SHALL have port cout, output, width 1: the final carry out (in sub mode, 1 means no borrow).
REQ-014 The block SHALL have port busy, output, width 1: high in state RUN.

Function
REQ-015 The block SHALL compute the full-width result with one shared 4-bit ripple-carry adder, processing one nibble per clock from least-significant upward.
REQ-016 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1, and out_valid and busy SHALL be 0.
REQ-018 A handshake (in_valid=1 while in_ready=1) SHALL capture a, b (inverted when sub=1) and the initial carry (sub ? 1 : cin), clear the nibble index to 0, and move to RUN.
REQ-019 In RUN, each cycle SHALL add the captured nibbles at the current index plus the carry register, write the 4-bit result into sum[4*idx+:4], update the carry register and increment the index.
REQ-020 When the index NIB-1 is processed, the block SHALL move to DONE and latch cout from the final carry.
REQ-021 Latency SHALL be exactly NIB+1 cycles from the accepting edge to the first edge at which out_valid=1 is sampled, with no bubbles.
REQ-022 In DONE, out_valid SHALL be 1, and sum and cout SHALL be held stable until out_ready=1.
REQ-023 When out_valid and out_ready are both 1, the block SHALL return to IDLE on that edge.
REQ-024 No same-cycle re-accept SHALL occur; in_ready SHALL rise the cycle after the result is consumed.
REQ-025 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored in those states and the captured operands SHALL NOT change.
REQ-026 Input changes to a, b, sub and cin after acceptance SHALL have no effect on the result.
REQ-027 Arithmetic SHALL be modulo 2^(4*NIB), with the carry beyond the MSB reported only on cout.
REQ-028 The all-ones + 1 case SHALL wrap sum to 0 with cout=1.
REQ-029 If out_ready is held at 0 indefinitely, the block SHALL stall in DONE without corrupting the result.

Reset
REQ-030 When rst_n=0, the state SHALL become IDLE immediately (asynchronously) and the index, carry register, operand registers, sum and cout SHALL clear to 0.
REQ-031 During reset, in_ready SHALL be 0; in_ready SHALL be 1 from the first clock edge after rst_n is deasserted.
REQ-032 A reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse and no partial result visible afterwards.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the nibble width constant 4 and the index-width function clog2(NIB).
REQ-034 The block SHALL instantiate the existing 4-bit ripple-carry adder exactly once as its single datapath sub-module (ripple_carry_adder); no other arithmetic operator SHALL be used on the operands.

Verification
REQ-035 Scenario, NIB=4, add: a=0x1234, b=0x0FFF, cin=0 -> sum=0x2233, cout=0; out_valid rises 5 cycles after the accept edge.
REQ-036 Scenario, wrap: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-037 Scenario, subtract: sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; with a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-038 Scenario, back-pressure: out_ready=0 for 10 cycles in DONE while in_valid=1 is driven with new operands -> in_ready=0 throughout, sum is unchanged, and the next accept occurs only after the consume edge.
REQ-039 Scenario, reset mid-operation: rst_n pulsed low during the 2nd RUN cycle -> immediately IDLE, sum=0, no out_valid; the next request computes correctly.
REQ-040 Scenario, random: 1000 random a/b/sub/cin transactions with random out_ready -> every result matches a reference model, with exactly one out_valid transaction per accepted input.
